tff_mod_counter: RTL
====================

# tff_mod_counter

Parametrised modulo-N up/down counter built as a bank of T flip-flops: each bit toggles when its computed toggle enable is high. It generalises the single toggle flip-flop to WIDTH bits with a configurable modulus, direction, parallel load, wrap or saturate mode, a terminal-count strobe and a toggle-divider output. It serves as the general event counter and clock-enable divider for timing and sequencing logic.

## Interface
- WIDTH, 4, counter width in bits; minimum 2.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2^WIDTH.
- SATURATE, 0, selects end-of-range behaviour: 0 wraps, 1 holds at the end value.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clock clk.
- en  input  1  step enable; one count step per enabled cycle.
- up  input  1  direction: 1 counts up, 0 counts down; sampled when en=1.
- load  input  1  parallel load request.
- din  input  WIDTH  value to load.
- clr_ovf  input  1  clears the sticky ovf flag.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal-count strobe (combinational from registered state and inputs).
- div_out  output  1  toggle output; flips on every terminal step.
- ovf  output  1  sticky flag; set by any terminal step.
- load_err  output  1  registered one-cycle pulse on an illegal load.

## Operation
- Next state has the form count ^ t_vec. t_vec is the per-bit toggle vector, computed from count, up, en, load, din and the end condition.
- The end value is MODULUS-1 when up=1 and 0 when up=0.
- Terminal step: en=1, load=0, reset=0, and count equals the end value.
- Priority, highest first: reset, then load, then en.
- On reset:
  - count=0, div_out=0, ovf=0, load_err=0.
  - tc=0, because tc is gated by reset.
- On load=1:
  - If din < MODULUS: count=din.
  - If din >= MODULUS: count is unchanged and load_err=1 for the next cycle.
  - en is ignored in a load cycle. A load never produces a terminal step.
- On en=1 with no load:
  - up=1: count increments. At MODULUS-1 it goes to 0 if SATURATE=0 and holds if SATURATE=1.
  - up=0: count decrements. At 0 it goes to MODULUS-1 if SATURATE=0 and holds if SATURATE=1.
- en=0 with no load: count holds and tc=0.
- tc = en & ~load & ~reset & (count == end value). It is high in the same cycle as the terminal step.
- div_out toggles at each rising edge where tc=1, in both wrap and saturate mode.
- ovf is set at each edge where tc=1. clr_ovf=1 clears it. If set and clear coincide, set wins.
- load_err is 0 in every cycle not caused by an illegal load.
- Changing direction mid-count is legal. The step always uses the current up value.

## Timing
- Latency: count, div_out, ovf and load_err update one edge after the qualifying inputs.
- tc is combinational: valid in the cycle before the edge that wraps or holds.
- Reset mid-count: count reads 0 after the next edge, regardless of load or en in that cycle.
- Reset asserted with clr_ovf or load in the same cycle: the reset values win.
- With SATURATE=1 and en held at the end value: tc stays high every cycle, div_out toggles every cycle, count stays constant.
- MODULUS=2^WIDTH: wrap is the natural binary rollover, and the din >= MODULUS check never fires.

## Test plan
- Reset, then en=1 and up=1 for 12 cycles (WIDTH=4, MODULUS=10) -> count runs 0..9, then 0, 1, 2. tc is high only while count=9. div_out goes 0 -> 1 at the wrap. ovf=1.
- From count=0, en=1, up=0 (SATURATE=0) -> tc high in the first cycle, count=9 next, div_out toggles. With SATURATE=1 -> count stays 0, tc stays high, div_out toggles every cycle.
- load=1, din=7, en=1 -> count=7, no step, tc=0. Then load=1, din=12 -> count stays 7 and load_err is a one-cycle pulse.
- ovf=1, then clr_ovf=1 in the same cycle as a terminal step -> ovf stays 1. Next cycle, clr_ovf=1 with no tc -> ovf=0.
- Count at 5 with en=1, then reset=1 together with load=1, din=3 -> count=0, div_out=0, ovf=0, load_err=0, tc=0 during reset.
- Alternate up each cycle starting from count=4 with en=1 -> count 5, 4, 5, 4. No tc, no ovf.

Source files
------------

// File: rtl/tff_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tff_mod_counter
//  Purpose  : Modulo-N up/down counter built as a bank of T flip-flops. Each
//             count bit toggles when its toggle-enable bit is set; the toggle
//             vector is the XOR of the current and the desired next count.
//             Supports parallel load with range check, wrap or saturate at
//             the end of range, a terminal-count strobe, a divider toggle
//             output and a sticky overflow flag.
//  Ports    : clk       - clock, rising edge
//             reset     - synchronous active-high reset
//             en        - step enable
//             up        - direction (1 = up, 0 = down)
//             load/din  - parallel load request / value
//             clr_ovf   - clear sticky ovf
//             count     - registered count
//             tc        - terminal-count strobe (combinational)
//             div_out   - toggles on every terminal step
//             ovf       - sticky terminal-step flag
//             load_err  - one-cycle pulse after an out-of-range load
//  Revision : 1.0 - initial release
// ============================================================================
module tff_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             div_out,
    output logic             ovf,
    output logic             load_err
);

    // MODULUS may equal 2^WIDTH, so the range check needs one extra bit.
    localparam int             c_MOD_M1  = MODULUS - 1;
    localparam logic [WIDTH:0] c_MOD     = MODULUS[WIDTH:0];
    localparam logic [WIDTH-1:0] c_END_UP = c_MOD_M1[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_ZERO   = '0;
    localparam logic [WIDTH-1:0] c_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_div;
    logic             r_ovf;
    logic             r_load_err;

    logic [WIDTH-1:0] w_end;
    logic             w_at_end;
    logic             w_din_bad;
    logic             w_tc;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_tvec;

    assign w_end     = up ? c_END_UP : c_ZERO;
    assign w_at_end  = (r_count == w_end);
    assign w_din_bad = ({1'b0, din} >= c_MOD);
    assign w_tc      = en & ~load & ~reset & w_at_end;

    // Desired next count; the toggle vector is derived from it so that the
    // state register is a pure T flip-flop bank (count ^ t_vec).
    always_comb begin
        w_next = r_count;
        if (load) begin
            if (!w_din_bad) begin
                w_next = din;
            end
        end else if (en) begin
            if (w_at_end) begin
                if (!SATURATE) begin
                    w_next = up ? c_ZERO : c_END_UP;
                end
            end else begin
                w_next = up ? (r_count + c_ONE) : (r_count - c_ONE);
            end
        end
    end

    assign w_tvec = r_count ^ w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_div      <= 1'b0;
            r_ovf      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= r_count ^ w_tvec;
            r_div      <= r_div ^ w_tc;
            // A terminal step takes precedence over a simultaneous clear.
            r_ovf      <= w_tc | (r_ovf & ~clr_ovf);
            r_load_err <= load & w_din_bad;
        end
    end

    assign count    = r_count;
    assign tc       = w_tc;
    assign div_out  = r_div;
    assign ovf      = r_ovf;
    assign load_err = r_load_err;

endmodule
`default_nettype wire
